// File: rtl/arith_result_fifo.sv
// First-word-fall-through result buffer for the 16-bit arithmetic unit.
// Stores {op, data} pairs; writes that arrive while full are dropped and counted.
module arith_result_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_op,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_op,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [7:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [1:0]        mem_op   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  // Counter that sticks at its ceiling so a long overflow burst never reads as small.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem_data[rd_ptr];
  assign out_op    = mem_op[rd_ptr];

  assign push = in_valid && !full;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && full;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_op[i]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= in_data;
        mem_op[wr_ptr]   <= in_op;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (drop) begin
        drop_cnt <= sat_inc8(drop_cnt);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_result_fifo.sv
// Directed bench for arith_result_fifo: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_arith_result_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_op;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_op;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  arith_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_op(in_op), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of {op, data} plus a saturating drop tally.
  logic [DATA_W+1:0] q[$];
  int  mdrop = 0;
  bit  started = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      mdrop   = 0;
      started = 1;
    end else if (started) begin
      bit was_full;
      was_full = (q.size() == DEPTH);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid) begin
        if (was_full) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        else q.push_back({in_op, in_data});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_count",     32'(count),     32'(q.size()));
      check("m_empty",     32'(empty),     32'(q.size() == 0));
      check("m_full",      32'(full),      32'(q.size() == DEPTH));
      check("m_in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
      check("m_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("m_drop_cnt",  32'(drop_cnt),  32'(mdrop));
      if (q.size() != 0) begin
        check("m_out_data", 32'(out_data), 32'(q[0][DATA_W-1:0]));
        check("m_out_op",   32'(out_op),   32'(q[0][DATA_W+1:DATA_W]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] op,
                       input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 2'b00, 1'b0);
    step();
    step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_empty",    32'(empty),     32'd1);
      check("rst_in_ready", 32'(in_ready),  32'd1);
      check("rst_count",    32'(count),     32'd0);
      check("rst_out_data", 32'(out_data),  32'd0);
      check("rst_out_op",   32'(out_op),    32'd0);
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_full",     32'(full),      32'd0);
      check("rst_drop",     32'(drop_cnt),  32'd0);
    end

    // Three pushes, then ordered drain
    drive(1'b1, 16'h0005, 2'b00, 1'b0); step(); check("push1_count", 32'(count), 32'd1);
    check("push1_head", 32'(out_data), 32'h0005);
    drive(1'b1, 16'h0003, 2'b01, 1'b0); step(); check("push2_count", 32'(count), 32'd2);
    drive(1'b1, 16'hFFFF, 2'b11, 1'b0); step(); check("push3_count", 32'(count), 32'd3);
    drive(1'b0, '0, 2'b00, 1'b1);
    check("pop1_data", 32'(out_data), 32'h0005); check("pop1_op", 32'(out_op), 32'd0);
    step();
    check("pop2_data", 32'(out_data), 32'h0003); check("pop2_op", 32'(out_op), 32'd1);
    step();
    check("pop3_data", 32'(out_data), 32'hFFFF); check("pop3_op", 32'(out_op), 32'd3);
    step();
    check("drained_empty", 32'(empty), 32'd1);

    // Fill, drop one write while full, then drain
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'(16'h0010 + i), 2'(i), 1'b0);
      step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0099, 2'b10, 1'b0); step();
    check("drop1_cnt", 32'(drop_cnt), 32'd1);
    check("drop1_count", 32'(count), 32'd4);
    check("drop1_head", 32'(out_data), 32'h0010);
    drive(1'b0, '0, 2'b00, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(out_data), 32'h0010 + 32'(i));
      step();
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous push and pop: pop happens, push is dropped
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'(16'h0020 + i), 2'b01, 1'b0);
      step();
    end
    drive(1'b1, 16'h0077, 2'b11, 1'b1); step();
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_drop", 32'(drop_cnt), 32'd2);
    check("fullpop_head", 32'(out_data), 32'h0021);
    drive(1'b0, '0, 2'b00, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      check("fullpop_drain", 32'(out_data), 32'h0020 + 32'(i));
      step();
    end
    check("fullpop_empty", 32'(empty), 32'd1);

    // Streaming: push and pop every cycle, pointers wrap several times
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'(i), 2'(i), 1'b1);
      step();
      check("stream_count", 32'(count), 32'd1);
      check("stream_data", 32'(out_data), 32'(i));
      check("stream_op", 32'(out_op), 32'(i % 4));
    end
    drive(1'b0, '0, 2'b00, 1'b1); step();
    check("stream_empty", 32'(empty), 32'd1);

    // Saturate drop counter, then reset with entries buffered and a write pending
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'(16'h0030 + i), 2'b00, 1'b0);
      step();
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'hBEEF, 2'b11, 1'b0);
      step();
    end
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_count", 32'(count), 32'd4);
    check("sat_head", 32'(out_data), 32'h0030);
    drive(1'b0, '0, 2'b00, 1'b1); step();
    check("pre_rst_count", 32'(count), 32'd3);
    drive(1'b1, 16'h1234, 2'b01, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, '0, 2'b00, 1'b0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_op", 32'(out_op), 32'd0);
    step();
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arith_result_fifo.md
# arith_result_fifo

Downstream stage of the 16-bit arithmetic unit: captures each result word (`data_out`) with the op-select code that produced it and buffers them in a small first-word-fall-through FIFO. A downstream consumer drains the FIFO through a valid/ready handshake. Writes that arrive while the FIFO is full are dropped and counted, so result loss is visible to software and debug.

## Interface
Parameters:
- `DATA_W`, default 16, result width; matches the arithmetic unit output.
- `DEPTH`, default 4, number of entries; power of two, minimum 2.
- `CNT_W`, default `$clog2(DEPTH)+1`, width of `count`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  result present this cycle.
- `in_data`  in  DATA_W  result word from the arithmetic unit.
- `in_op`  in  2  op-select code paired with `in_data`.
- `in_ready`  out  1  FIFO can accept a write; equals `!full`.
- `out_valid`  out  1  head entry valid; equals `!empty`.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_data`  out  DATA_W  head entry result.
- `out_op`  out  2  head entry op code.
- `count`  out  CNT_W  occupied entries, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `drop_cnt`  out  8  saturating count of dropped writes.

## Operation
- Storage: DEPTH entries of {`in_op`, `in_data`}, plus write pointer, read pointer and `count` registers. Pointers are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0.
- Push: `in_valid && !full` at a rising edge. Writes the entry at the write pointer and increments the write pointer.
- Pop: `out_valid && out_ready` at a rising edge. Increments the read pointer.
- Drop: `in_valid && full`. No write occurs and `drop_cnt` increments. `drop_cnt` saturates at 255 and holds.
- `count` update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, both pointers advance
  - neither: hold
- Full and pop in the same cycle: `in_ready` reflects the pre-edge `full`, so a concurrent `in_valid` is dropped. There is no pass-through write when full.
- Empty and push in the same cycle: `out_valid` is 0, so no pop occurs regardless of `out_ready`. The entry appears at the head on the next cycle.
- Output: first-word-fall-through. `out_data`/`out_op` are driven combinationally from the entry at the read pointer.
- Output stability: `out_data`/`out_op` stay stable while `out_valid && !out_ready`.
- Reset (synchronous, takes priority over push and pop in the same cycle):
  - clears pointers, `count`, `drop_cnt` and all storage entries to 0
  - post-reset outputs: `empty=1`, `full=0`, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_op=0`, `count=0`, `drop_cnt=0`
- Reset mid-operation: discards all buffered entries. Handshakes in the reset cycle have no effect, and a drop in that cycle is not counted.
- Width rules:
  - `in_data` is stored unmodified; no truncation or extension.
  - `count` is CNT_W bits so it can hold DEPTH.
  - `drop_cnt` never wraps.

## Timing
- Write-to-read latency: an entry pushed at edge N is visible on `out_data` with `out_valid=1` after edge N (one cycle).
- `full`, `empty`, `count`, `in_ready` and `out_valid` are decoded from registered state. They change only after a rising edge, with no combinational path from `in_valid` or `out_ready`.
- `out_data`/`out_op` change only after a pop edge, a push-into-empty edge, or reset.
- Sustained throughput: one push and one pop per cycle when `0 < count < DEPTH`.
- `drop_cnt` updates on the edge where the drop condition is sampled.

## Test plan
- Reset, then idle: all outputs at their reset values (`empty=1`, `in_ready=1`, `count=0`, `out_data=0`) for 3 cycles.
- Push 0x0005/op 00, 0x0003/op 01, 0xFFFF/op 11 on consecutive cycles with `out_ready=0` → `count` reads 1, 2, 3. Then set `out_ready=1` → pops return them in order (0x0005/00, 0x0003/01, 0xFFFF/11) and `empty=1` after the third pop.
- Fill to DEPTH=4 with 0x0010..0x0013, then push 0x0099 while `full` → `drop_cnt=1`, `count=4`. Draining yields 0x0010..0x0013 only; 0x0099 never appears.
- Full with `in_valid=1` and `out_ready=1` in the same cycle → one pop, the write is dropped, `count=3`, `drop_cnt` +1.
- Continuous push/pop for 12 cycles with data = cycle index → `count` stays at 1, the output sequence is in order, and the pointers wrap at least twice without error.
- 300 writes while full → `drop_cnt` saturates at 255. Assert `reset` with `count=3` and `in_valid=1` → next cycle `count=0`, `out_valid=0`, `drop_cnt=0`.
